alu_rs_multi: RTL and testbench
===============================

// Module: alu_rs_multi
// PURPOSE
//  Multi-entry ALU reservation station with an integrated single-cycle ALU.
//  Accepts dispatched ops whose operands may still be pending on ROB tags, and captures them from CDB channels.
//  Issues one ready entry per cycle to the ALU and broadcasts {rob_id, value} as a CDB producer.
//  Sits between the dispatcher/ROB and the CDB; replaces the single-slot ALU stage.
// PARAMETERS
//  RS_DEPTH  8   number of entries (power of two, >=2)
//  XLEN      32  operand/result width
//  ROB_W     4   ROB tag width (matches `ROB_WIDTH)
//  OP_W      9   op code width; encodings per team opcode defines (LUI..AND)
//  CDB_N     2   number of CDB channels snooped for wakeup
// PORTS
//  clk_in        in   1              system clock
//  rst_n_in      in   1              synchronous reset, active-low
//  rdy_in        in   1              global ready; low = freeze
//  clear         in   1              mispredict flush
//  disp_en       in   1              dispatch strobe
//  disp_op       in   OP_W           op code
//  disp_vj       in   XLEN           lhs value (valid when !disp_qj_vld)
//  disp_qj_vld   in   1              lhs pending on ROB tag disp_qj
//  disp_qj       in   ROB_W          lhs producer tag
//  disp_vk       in   XLEN           rhs value/immediate (valid when !disp_qk_vld)
//  disp_qk_vld   in   1              rhs pending on ROB tag disp_qk
//  disp_qk       in   ROB_W          rhs producer tag
//  disp_rob      in   ROB_W          destination ROB tag
//  cdb_vld       in   CDB_N          per-channel broadcast valid
//  cdb_rob       in   CDB_N*ROB_W    per-channel tag, channel i at [i*ROB_W +: ROB_W]
//  cdb_val       in   CDB_N*XLEN     per-channel value
//  full          out  1              all entries occupied
//  ready         out  1              result valid this cycle
//  rob_id        out  ROB_W          result ROB tag
//  value         out  XLEN           result value
// BEHAVIOUR
//  - Reset (rst_n_in=0 at posedge): all entries invalid; ready=0, rob_id=0, value=0. full=0 follows.
//  - Priority per posedge: reset > (rdy_in & clear) > !rdy_in freeze > normal.
//  - clear: all entries invalid; ready<=0; same-cycle dispatch dropped.
//  - !rdy_in: entry state held; ready<=0; rob_id/value held.
//  - Entry state: busy, op, vj, qj_vld, qj, vk, qk_vld, qk, rob.
//  - full: combinational, = AND of all busy bits at cycle start.
//    A disp_en while full is ignored; the dispatcher must not do this.
//  - Dispatch: written into the lowest-index non-busy entry.
//    An entry freed by issue in the same cycle cannot be reused until the next cycle.
//  - Wakeup: each busy entry with qj_vld compares qj against every channel i with cdb_vld[i].
//    On match: vj<=cdb_val[i], qj_vld<=0. Same for qk.
//    If several channels carry the same tag, the lowest channel wins.
//  - Entry ready = busy & !qj_vld & !qk_vld, evaluated on registered state.
//    A CDB match is therefore issuable the following cycle.
//  - Select: the lowest-index ready entry issues. It is freed (busy<=0) at the same posedge.
//    ready<=1, rob_id<=entry.rob, value<=ALU(op, vj, vk).
//  - No entry ready: ready<=0. rob_id/value hold.
//  - Latency: dispatch with both operands ready at cycle t -> ready=1 at cycle t+2.
//    CDB match at cycle t -> ready at t+2 at earliest.
//  - ALU semantics (XLEN bits, wrap-around arithmetic):
//    LUI=lhs; AUIPC/JAL/ADD(I)=lhs+rhs; JALR=(lhs+rhs)&~1; SUB=lhs-rhs.
//    SLT(I)/SLTU(I)=zero-extended compare. XOR/OR/AND(I) bitwise.
//    SLL/SRL/SRA(I) use shamt=rhs[4:0]; SRA is arithmetic.
//    Branches return all-ones if taken, all-zeros otherwise: BEQ, BNE, BLT, BGE signed, BLTU, BGEU unsigned.
//    Undefined op -> 0.
//  - Own result is not forwarded internally; wiring it back as a CDB channel is the integrator's job.
// CONFIGURATION
//  ALU_RS_DISP_FWD_EN defined:
//    Dispatched operand with q*_vld whose tag matches a same-cycle valid CDB channel is stored already resolved.
//    Its value is the CDB value, and it is issuable next cycle.
//  ALU_RS_DISP_FWD_EN undefined:
//    Dispatched tags are stored as-is; same-cycle CDB broadcasts are missed.
//    The dispatcher must resolve such operands from the ROB itself.
// TESTING
//  1. Reset, dispatch ADDI vj=5 vk=7 rob=3 (no deps) -> 2 cycles later ready=1, rob_id=3, value=12. Next cycle ready=0.
//  2. Dispatch ADD qj=2 pending, vk=1 rob=4; CDB ch0 tag 2 value 0xFFFFFFFF one cycle later
//     -> ready with rob_id=4, value=0 (wrap) two cycles after the CDB.
//  3. Fill 8 entries all pending -> full=1; 9th disp_en ignored.
//     Broadcast each tag in turn -> results in index order; full drops after first issue.
//  4. Three ready entries, clear asserted -> next cycle ready=0, full=0. No result for any of them ever appears.
//  5. rdy_in=0 for 3 cycles with ready entries -> ready=0 throughout.
//     Issue resumes on the first rdy_in=1 cycle, in unchanged order.
//  6. Compute: SRA lhs=0x80000000 rhs=4 -> 0xF8000000. BLT lhs=-1 rhs=0 -> 0xFFFFFFFF. BLTU same operands -> 0.
//     JALR 0x1003+0 -> 0x1002.
//     With ALU_RS_DISP_FWD_EN: dispatch qj=6 while CDB carries tag 6 -> issues without a later broadcast.

Source files
------------

// File: rtl/alu_rs_multi_if.sv
// rtl/alu_rs_multi_if.sv - dispatch, CDB snoop and result bus of the ALU reservation station
interface alu_rs_multi_if #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int OP_W  = 9,
  parameter int CDB_N = 2
);
  logic                   rdy_in;
  logic                   clear;
  logic                   disp_en;
  logic [OP_W-1:0]        disp_op;
  logic [XLEN-1:0]        disp_vj;
  logic                   disp_qj_vld;
  logic [ROB_W-1:0]       disp_qj;
  logic [XLEN-1:0]        disp_vk;
  logic                   disp_qk_vld;
  logic [ROB_W-1:0]       disp_qk;
  logic [ROB_W-1:0]       disp_rob;
  logic [CDB_N-1:0]       cdb_vld;
  logic [CDB_N*ROB_W-1:0] cdb_rob;
  logic [CDB_N*XLEN-1:0]  cdb_val;
  logic                   full;
  logic                   ready;
  logic [ROB_W-1:0]       rob_id;
  logic [XLEN-1:0]        value;

  modport master (
    output rdy_in, clear, disp_en, disp_op, disp_vj, disp_qj_vld, disp_qj,
           disp_vk, disp_qk_vld, disp_qk, disp_rob, cdb_vld, cdb_rob, cdb_val,
    input  full, ready, rob_id, value
  );

  modport slave (
    input  rdy_in, clear, disp_en, disp_op, disp_vj, disp_qj_vld, disp_qj,
           disp_vk, disp_qk_vld, disp_qk, disp_rob, cdb_vld, cdb_rob, cdb_val,
    output full, ready, rob_id, value
  );
endinterface

// File: rtl/alu_rs_multi.sv
// rtl/alu_rs_multi.sv - multi-entry ALU reservation station with CDB wakeup and integrated ALU
// Optional ALU_RS_DISP_FWD_EN: resolve dispatched operands from a same-cycle CDB broadcast.
module alu_rs_multi #(
  parameter int RS_DEPTH = 8,
  parameter int XLEN     = 32,
  parameter int ROB_W    = 4,
  parameter int OP_W     = 9,
  parameter int CDB_N    = 2
) (
  input logic          clk_in,
  input logic          rst_n_in,
  alu_rs_multi_if.slave bus
);
  localparam int IDX_W = $clog2(RS_DEPTH);

  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(1),  OP_AUIPC = OP_W'(2),  OP_JAL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(4),  OP_BEQ   = OP_W'(5),  OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(7),  OP_BGE   = OP_W'(8),  OP_BLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(10), OP_ADDI  = OP_W'(11), OP_SLTI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13), OP_XORI = OP_W'(14), OP_ORI   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(16), OP_SLLI  = OP_W'(17), OP_SRLI  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_SRAI = OP_W'(19), OP_ADD   = OP_W'(20), OP_SUB   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(22), OP_SLT   = OP_W'(23), OP_SLTU  = OP_W'(24);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(25), OP_SRL   = OP_W'(26), OP_SRA   = OP_W'(27);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(28), OP_AND   = OP_W'(29);

  logic [RS_DEPTH-1:0] busy, qj_vld, qk_vld, ent_rdy;
  logic [OP_W-1:0]     op  [RS_DEPTH];
  logic [XLEN-1:0]     vj  [RS_DEPTH];
  logic [XLEN-1:0]     vk  [RS_DEPTH];
  logic [ROB_W-1:0]    qj  [RS_DEPTH];
  logic [ROB_W-1:0]    qk  [RS_DEPTH];
  logic [ROB_W-1:0]    rob [RS_DEPTH];

  // {still_pending, value}; channels scanned high to low so the lowest matching channel wins
  function automatic logic [XLEN:0] snoop(
    input logic                   pend,
    input logic [ROB_W-1:0]       tag,
    input logic [XLEN-1:0]        val,
    input logic [CDB_N-1:0]       c_vld,
    input logic [CDB_N*ROB_W-1:0] c_rob,
    input logic [CDB_N*XLEN-1:0]  c_val
  );
    logic [XLEN:0] r;
    r = {pend, val};
    for (int c = CDB_N - 1; c >= 0; c--) begin
      if (pend && c_vld[c] && tag == c_rob[c*ROB_W +: ROB_W])
        r = {1'b0, c_val[c*XLEN +: XLEN]};
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] alu(
    input logic [OP_W-1:0] f,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN-1:0] r;
    r = '0;
    case (f)
      OP_LUI:                             r = a;
      OP_AUIPC, OP_JAL, OP_ADD, OP_ADDI:  r = a + b;
      OP_JALR:                            r = (a + b) & ~XLEN'(1);
      OP_SUB:                             r = a - b;
      OP_SLT, OP_SLTI:                    r = XLEN'($signed(a) < $signed(b));
      OP_SLTU, OP_SLTIU:                  r = XLEN'(a < b);
      OP_XOR, OP_XORI:                    r = a ^ b;
      OP_OR, OP_ORI:                      r = a | b;
      OP_AND, OP_ANDI:                    r = a & b;
      OP_SLL, OP_SLLI:                    r = a << b[4:0];
      OP_SRL, OP_SRLI:                    r = a >> b[4:0];
      OP_SRA, OP_SRAI:                    r = $signed(a) >>> b[4:0];
      OP_BEQ:                             r = {XLEN{a == b}};
      OP_BNE:                             r = {XLEN{a != b}};
      OP_BLT:                             r = {XLEN{$signed(a) < $signed(b)}};
      OP_BGE:                             r = {XLEN{$signed(a) >= $signed(b)}};
      OP_BLTU:                            r = {XLEN{a < b}};
      OP_BGEU:                            r = {XLEN{a >= b}};
      default:                            r = '0;
    endcase
    return r;
  endfunction

  assign ent_rdy  = busy & ~qj_vld & ~qk_vld;
  assign bus.full = &busy;

  logic             issue_vld, alloc_vld;
  logic [IDX_W-1:0] issue_idx, alloc_idx;

  // Both pick the lowest index; alloc looks at registered busy, so a slot freed by issue waits a cycle.
  always_comb begin
    issue_vld = 1'b0;
    issue_idx = '0;
    alloc_vld = 1'b0;
    alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (ent_rdy[i]) begin
        issue_vld = 1'b1;
        issue_idx = i[IDX_W-1:0];
      end
      if (!busy[i]) begin
        alloc_vld = 1'b1;
        alloc_idx = i[IDX_W-1:0];
      end
    end
  end

  logic [XLEN:0] wj [RS_DEPTH];
  logic [XLEN:0] wk [RS_DEPTH];

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      wj[i] = snoop(qj_vld[i], qj[i], vj[i], bus.cdb_vld, bus.cdb_rob, bus.cdb_val);
      wk[i] = snoop(qk_vld[i], qk[i], vk[i], bus.cdb_vld, bus.cdb_rob, bus.cdb_val);
    end
  end

  logic [XLEN:0] dj, dk;
`ifdef ALU_RS_DISP_FWD_EN
  assign dj = snoop(bus.disp_qj_vld, bus.disp_qj, bus.disp_vj, bus.cdb_vld, bus.cdb_rob, bus.cdb_val);
  assign dk = snoop(bus.disp_qk_vld, bus.disp_qk, bus.disp_vk, bus.cdb_vld, bus.cdb_rob, bus.cdb_val);
`else
  assign dj = {bus.disp_qj_vld, bus.disp_vj};
  assign dk = {bus.disp_qk_vld, bus.disp_vk};
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      busy       <= '0;
      bus.ready  <= 1'b0;
      bus.rob_id <= '0;
      bus.value  <= '0;
    end else if (bus.rdy_in && bus.clear) begin
      busy      <= '0;
      bus.ready <= 1'b0;
    end else if (!bus.rdy_in) begin
      bus.ready <= 1'b0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy[i]) begin
          qj_vld[i] <= wj[i][XLEN];
          vj[i]     <= wj[i][XLEN-1:0];
          qk_vld[i] <= wk[i][XLEN];
          vk[i]     <= wk[i][XLEN-1:0];
        end
      end
      if (issue_vld) begin
        busy[issue_idx] <= 1'b0;
        bus.ready       <= 1'b1;
        bus.rob_id      <= rob[issue_idx];
        bus.value       <= alu(op[issue_idx], vj[issue_idx], vk[issue_idx]);
      end else begin
        bus.ready <= 1'b0;
      end
      if (bus.disp_en && alloc_vld) begin
        busy[alloc_idx]   <= 1'b1;
        op[alloc_idx]     <= bus.disp_op;
        qj_vld[alloc_idx] <= dj[XLEN];
        vj[alloc_idx]     <= dj[XLEN-1:0];
        qj[alloc_idx]     <= bus.disp_qj;
        qk_vld[alloc_idx] <= dk[XLEN];
        vk[alloc_idx]     <= dk[XLEN-1:0];
        qk[alloc_idx]     <= bus.disp_qk;
        rob[alloc_idx]    <= bus.disp_rob;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs_multi.sv
// tb/tb_alu_rs_multi.sv - directed scoreboard bench for alu_rs_multi
module tb_alu_rs_multi;
  localparam int XLEN = 32, ROB_W = 4, OP_W = 9, CDB_N = 2;

  localparam logic [8:0] OP_JALR = 9'd4,  OP_BLT = 9'd7,  OP_BLTU = 9'd9,  OP_ADDI = 9'd11;
  localparam logic [8:0] OP_ADD  = 9'd20, OP_SUB = 9'd21, OP_SLTU = 9'd24, OP_SRA  = 9'd27;
  localparam logic [8:0] OP_BAD  = 9'd300;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [ROB_W+XLEN-1:0] exp_q[$];

  alu_rs_multi_if #(.XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .CDB_N(CDB_N)) bus ();

  alu_rs_multi #(.RS_DEPTH(8), .XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .CDB_N(CDB_N)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp(input logic [8:0] op, input logic [31:0] vj, input logic qjv, input logic [3:0] qj,
                      input logic [31:0] vk, input logic qkv, input logic [3:0] qk, input logic [3:0] rob);
    bus.disp_en = 1'b1;
    bus.disp_op = op;
    bus.disp_vj = vj;
    bus.disp_qj_vld = qjv;
    bus.disp_qj = qj;
    bus.disp_vk = vk;
    bus.disp_qk_vld = qkv;
    bus.disp_qk = qk;
    bus.disp_rob = rob;
  endtask

  task automatic cdb(input int ch, input logic [3:0] tag, input logic [31:0] val);
    bus.cdb_vld[ch] = 1'b1;
    bus.cdb_rob[ch*ROB_W +: ROB_W] = tag;
    bus.cdb_val[ch*XLEN +: XLEN] = val;
  endtask

  task automatic push(input logic [3:0] rob, input logic [31:0] val);
    exp_q.push_back({rob, val});
  endtask

  // Every result the DUT announces must be the next one the scoreboard expects.
  always @(negedge clk_in) begin
    if (rst_n_in && bus.ready === 1'b1) begin
      chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic [ROB_W+XLEN-1:0] e;
        e = exp_q.pop_front();
        chk("sb_rob_id", 64'(bus.rob_id), 64'(e[XLEN +: ROB_W]));
        chk("sb_value", 64'(bus.value), 64'(e[XLEN-1:0]));
      end
    end
  end

  initial begin
    bus.rdy_in = 1'b1;
    bus.clear = 1'b0;
    bus.disp_en = 1'b0;
    bus.disp_op = '0;
    bus.disp_vj = '0;
    bus.disp_qj_vld = 1'b0;
    bus.disp_qj = '0;
    bus.disp_vk = '0;
    bus.disp_qk_vld = 1'b0;
    bus.disp_qk = '0;
    bus.disp_rob = '0;
    bus.cdb_vld = '0;
    bus.cdb_rob = '0;
    bus.cdb_val = '0;

    tick();
    tick();
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_rob_id", 64'(bus.rob_id), 64'd0);
    chk("rst_value", 64'(bus.value), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    rst_n_in = 1'b1;

    // 1: no dependencies, result two cycles after dispatch
    disp(OP_ADDI, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
    push(4'd3, 32'd12);
    tick();
    bus.disp_en = 1'b0;
    chk("t1_ready_early", 64'(bus.ready), 64'd0);
    tick();
    chk("t1_ready", 64'(bus.ready), 64'd1);
    chk("t1_rob_id", 64'(bus.rob_id), 64'd3);
    chk("t1_value", 64'(bus.value), 64'd12);
    tick();
    chk("t1_ready_drop", 64'(bus.ready), 64'd0);

    // 2: lhs woken by CDB one cycle after dispatch, wrap-around add
    disp(OP_ADD, 32'h55, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0, 4'd4);
    push(4'd4, 32'd0);
    tick();
    bus.disp_en = 1'b0;
    cdb(0, 4'd2, 32'hFFFF_FFFF);
    tick();
    bus.cdb_vld = '0;
    chk("t2_wait", 64'(bus.ready), 64'd0);
    tick();
    chk("t2_ready", 64'(bus.ready), 64'd1);
    chk("t2_rob_id", 64'(bus.rob_id), 64'd4);
    chk("t2_value", 64'(bus.value), 64'd0);

    // 3: fill all entries, ignored dispatch while full, in-order wakeup
    for (int i = 0; i < 8; i++) begin
      disp(OP_ADDI, 32'd0, 1'b1, 4'(8 + i), 32'(3 * i), 1'b0, 4'd0, 4'(i));
      push(4'(i), 32'(100 * i + 1 + 3 * i));
      tick();
    end
    bus.disp_en = 1'b0;
    chk("t3_full", 64'(bus.full), 64'd1);
    disp(OP_ADDI, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd15);
    tick();
    bus.disp_en = 1'b0;
    chk("t3_full_hold", 64'(bus.full), 64'd1);
    for (int i = 0; i < 8; i++) begin
      cdb(i % 2, 4'(8 + i), 32'(100 * i + 1));
      if (i == 0) cdb(1, 4'd8, 32'd999);
      tick();
      bus.cdb_vld = '0;
      if (i == 1) chk("t3_full_drop", 64'(bus.full), 64'd0);
    end
    tick();
    tick();

    // 4: clear with three ready entries and a same-cycle dispatch
    for (int k = 0; k < 3; k++) begin
      disp(OP_ADD, 32'd0, 1'b1, 4'd5, 32'd10, 1'b0, 4'd0, 4'(5 + k));
      tick();
    end
    bus.disp_en = 1'b0;
    cdb(0, 4'd5, 32'd1);
    tick();
    bus.cdb_vld = '0;
    bus.clear = 1'b1;
    disp(OP_ADDI, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd9);
    tick();
    bus.clear = 1'b0;
    bus.disp_en = 1'b0;
    chk("t4_ready", 64'(bus.ready), 64'd0);
    chk("t4_full", 64'(bus.full), 64'd0);
    for (int k = 0; k < 4; k++) tick();

    // 5: freeze for three cycles, then resume in order
    for (int k = 0; k < 3; k++) begin
      disp(OP_ADD, 32'd0, 1'b1, 4'd3, 32'(20 + k), 1'b0, 4'd0, 4'(10 + k));
      push(4'(10 + k), 32'(27 + k));
      tick();
    end
    bus.disp_en = 1'b0;
    cdb(1, 4'd3, 32'd7);
    tick();
    bus.cdb_vld = '0;
    bus.rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_frozen", 64'(bus.ready), 64'd0);
    end
    chk("t5_hold_rob_id", 64'(bus.rob_id), 64'd7);
    bus.rdy_in = 1'b1;
    tick();
    chk("t5_resume", 64'(bus.ready), 64'd1);
    chk("t5_resume_rob_id", 64'(bus.rob_id), 64'd10);
    tick();
    tick();
    tick();

    // 6: ALU corner cases, back-to-back
    disp(OP_SRA, 32'h8000_0000, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd1);
    push(4'd1, 32'hF800_0000);
    tick();
    disp(OP_BLT, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd2);
    push(4'd2, 32'hFFFF_FFFF);
    tick();
    disp(OP_BLTU, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd3);
    push(4'd3, 32'd0);
    tick();
    disp(OP_JALR, 32'h1003, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd4);
    push(4'd4, 32'h1002);
    tick();
    disp(OP_SUB, 32'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 4'd5);
    push(4'd5, 32'hFFFF_FFFE);
    tick();
    disp(OP_SLTU, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd6);
    push(4'd6, 32'd1);
    tick();
    disp(OP_BAD, 32'd9, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 4'd7);
    push(4'd7, 32'd0);
    tick();
    bus.disp_en = 1'b0;
    tick();
    tick();
    tick();

    // 7: dispatch while the producer broadcasts in the same cycle
    disp(OP_ADD, 32'd0, 1'b1, 4'd6, 32'd4, 1'b0, 4'd0, 4'd13);
    cdb(0, 4'd6, 32'h10);
`ifdef ALU_RS_DISP_FWD_EN
    push(4'd13, 32'h14);
    tick();
    bus.disp_en = 1'b0;
    bus.cdb_vld = '0;
    tick();
    chk("t7_fwd_ready", 64'(bus.ready), 64'd1);
    chk("t7_fwd_value", 64'(bus.value), 64'h14);
`else
    tick();
    bus.disp_en = 1'b0;
    bus.cdb_vld = '0;
    tick();
    chk("t7_missed", 64'(bus.ready), 64'd0);
    tick();
    chk("t7_missed_late", 64'(bus.ready), 64'd0);
    cdb(0, 4'd6, 32'h20);
    push(4'd13, 32'h24);
    tick();
    bus.cdb_vld = '0;
    tick();
    chk("t7_rebroadcast_ready", 64'(bus.ready), 64'd1);
    chk("t7_rebroadcast_value", 64'(bus.value), 64'h24);
`endif
    tick();
    tick();
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
